count_seq_checker: RTL and testbench

- Passive monitor that sits on the output of a free-running enable-gated up counter: the consuming end of the counter's clock/reset/enable/count interface.
- Each cycle it predicts the next count from the sampled count, enable and counter-reset.
- Reports lock, mismatches, wrap-arounds and a sticky fault flag.
- Used in-system on counter outputs and as a self-checking block in counter benches.

---
 rtl/count_seq_checker.sv | 131 +++++++++++++
 tb/tb_count_seq_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Passive monitor for an enable-gated up counter. It predicts each next count from the last sample,
// locks after LOCK_THRESH good predictions, then flags, counts and latches any mismatch.
module count_seq_checker #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned LOCK_THRESH = 4,
  parameter int unsigned ECW         = 8,
  parameter int unsigned WCW         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cnt_reset,
  input  logic [WIDTH-1:0] counter_in,
  input  logic             clear,
  output logic             locked,
  output logic             error,
  output logic             fault,
  output logic [ECW-1:0]   error_count,
  output logic [WCW-1:0]   wrap_count
);

  typedef enum logic [1:0] {StIdle, StAcquire, StLocked, StFault} state_e;

  localparam logic [3:0] LastMatch = 4'(LOCK_THRESH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pred_q, pred_d;
  logic             pred_wrap_q, pred_wrap_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic             error_q, error_d;
  logic             fault_q, fault_d;
  logic [ECW-1:0]   err_cnt_q, err_cnt_d;
  logic [WCW-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic             match;

  // Case equality so an X/Z on the observed count can never count as a match.
  assign match = (counter_in === pred_q);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    error_d     = 1'b0;
    fault_d     = fault_q;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;

    // A new prediction is taken from every sample, whatever the state.
    if (cnt_reset) begin
      pred_d = '0;
    end else if (enable) begin
      pred_d = counter_in + WIDTH'(1);
    end else begin
      pred_d = counter_in;
    end
    pred_wrap_d = !cnt_reset && enable && (counter_in == '1);

    unique case (state_q)
      StIdle: begin
        match_cnt_d = '0;
        state_d     = StAcquire;
      end
      StAcquire: begin
        if (!match) begin
          match_cnt_d = '0;
        end else if (match_cnt_q == LastMatch) begin
          match_cnt_d = '0;
          state_d     = StLocked;
        end else begin
          match_cnt_d = match_cnt_q + 4'd1;
        end
      end
      StLocked: begin
        if (match) begin
          if (pred_wrap_q && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + WCW'(1);
          end
        end else begin
          error_d = 1'b1;
          fault_d = 1'b1;
          state_d = StFault;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ECW'(1);
          end
        end
      end
      StFault: begin
        match_cnt_d = '0;
        state_d     = StAcquire;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // clear wins over same-edge increments but leaves a fresh error visible in fault.
    if (clear) begin
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
      fault_d    = error_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pred_q      <= '0;
      pred_wrap_q <= 1'b0;
      match_cnt_q <= '0;
      error_q     <= 1'b0;
      fault_q     <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      pred_wrap_q <= pred_wrap_d;
      match_cnt_q <= match_cnt_d;
      error_q     <= error_d;
      fault_q     <= fault_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign locked      = (state_q == StLocked);
  assign error       = error_q;
  assign fault       = fault_q;
  assign error_count = err_cnt_q;
  assign wrap_count  = wrap_cnt_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed vector tables, hand-written corner sequences and a
// randomized run against an arithmetic reference model.
module tb_count_seq_checker;

  localparam int W    = 3;
  localparam int TH   = 4;
  localparam int ECW  = 2;
  localparam int WCW  = 3;
  localparam int CMOD = 1 << W;
  localparam int EMAX = (1 << ECW) - 1;
  localparam int WMAX = (1 << WCW) - 1;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           enable = 1'b0;
  logic           cnt_reset = 1'b0;
  logic [W-1:0]   counter_in = '0;
  logic           clear = 1'b0;
  logic           locked, error, fault;
  logic [ECW-1:0] error_count;
  logic [WCW-1:0] wrap_count;

  count_seq_checker #(
    .WIDTH       (W),
    .LOCK_THRESH (TH),
    .ECW         (ECW),
    .WCW         (WCW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .cnt_reset   (cnt_reset),
    .counter_in  (counter_in),
    .clear       (clear),
    .locked      (locked),
    .error       (error),
    .fault       (fault),
    .error_count (error_count),
    .wrap_count  (wrap_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: streak of consecutive good predictions since the last capture.
  bit m_started, m_fault_cyc, m_locked, m_err, m_fault, m_pred_wrap;
  int m_streak, m_pred, m_ec, m_wc;

  task automatic model_reset();
    m_started = 0; m_fault_cyc = 0; m_locked = 0; m_err = 0; m_fault = 0;
    m_pred_wrap = 0; m_streak = 0; m_pred = 0; m_ec = 0; m_wc = 0;
  endtask

  task automatic model_step(input int c, input bit e, input bit r, input bit clr);
    bit hit;
    hit   = (c == m_pred);
    m_err = 0;
    if (!m_started) begin
      m_started = 1;
      m_streak  = 0;
    end else if (m_fault_cyc) begin
      m_fault_cyc = 0;
      m_streak    = 0;
    end else if (m_locked) begin
      if (hit) begin
        if (m_pred_wrap && m_wc < WMAX) m_wc++;
      end else begin
        m_err       = 1;
        m_fault     = 1;
        m_fault_cyc = 1;
        m_streak    = 0;
        if (m_ec < EMAX) m_ec++;
      end
    end else begin
      m_streak = hit ? m_streak + 1 : 0;
    end
    m_locked = m_started && !m_fault_cyc && (m_streak >= TH);
    if (clr) begin
      m_ec    = 0;
      m_wc    = 0;
      m_fault = m_err;
    end
    m_pred      = r ? 0 : (e ? (c + 1) % CMOD : c);
    m_pred_wrap = !r && e && (c == CMOD - 1);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " locked"},      locked,      m_locked);
    chk({tag, " error"},       error,       m_err);
    chk({tag, " fault"},       fault,       m_fault);
    chk({tag, " error_count"}, error_count, m_ec);
    chk({tag, " wrap_count"},  wrap_count,  m_wc);
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic tick(input int c, input bit e, input bit r, input bit clr);
    counter_in = c[W-1:0];
    enable     = e;
    cnt_reset  = r;
    clear      = clr;
    @(posedge clock);
    model_step(c, e, r, clr);
    #1;
  endtask

  typedef struct {
    int c; bit e; bit r; bit clr;
    bit locked; bit error; bit fault; int ec; int wc;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(int c, bit e, bit r, bit clr, bit l, bit er, bit f, int ec, int wc);
    vec_t v;
    v.c = c; v.e = e; v.r = r; v.clr = clr;
    v.locked = l; v.error = er; v.fault = f; v.ec = ec; v.wc = wc;
    return v;
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tick(vecs[i].c, vecs[i].e, vecs[i].r, vecs[i].clr);
      chk($sformatf("vec%0d locked", i),      locked,      vecs[i].locked);
      chk($sformatf("vec%0d error", i),       error,       vecs[i].error);
      chk($sformatf("vec%0d fault", i),       fault,       vecs[i].fault);
      chk($sformatf("vec%0d error_count", i), error_count, vecs[i].ec);
      chk($sformatf("vec%0d wrap_count", i),  wrap_count,  vecs[i].wc);
    end
  endtask

  // Holds v with enable low; a FAULT/capture edge plus TH matches must lock.
  task automatic relock(input int v, input string tag);
    for (int k = 0; k < TH + 1; k++) begin
      tick(v, 0, 0, 0);
      check_model(tag);
    end
    chk({tag, " relocked"}, locked, 1);
  endtask

  initial begin
    int v;
    int true_cnt;
    bit e, r, clr;
    int c;

    // Scenario 1: idle at 0 after reset.
    for (int i = 0; i < 4; i++) vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[5] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Scenario 3: glitch 3 -> 5 while locked, then re-lock 5 edges later.
    vecs[6]  = mk(1, 1, 0, 0, 1, 0, 0, 0, 2);
    vecs[7]  = mk(2, 1, 0, 0, 1, 0, 0, 0, 2);
    vecs[8]  = mk(3, 1, 0, 0, 1, 0, 0, 0, 2);
    vecs[9]  = mk(5, 1, 0, 0, 0, 1, 1, 1, 2);
    vecs[10] = mk(6, 1, 0, 0, 0, 0, 1, 1, 2);
    vecs[11] = mk(7, 1, 0, 0, 0, 0, 1, 1, 2);
    vecs[12] = mk(0, 1, 0, 0, 0, 0, 1, 1, 2);
    vecs[13] = mk(1, 1, 0, 0, 0, 0, 1, 1, 2);
    vecs[14] = mk(2, 1, 0, 0, 1, 0, 1, 1, 2);

    model_reset();
    #22;
    check_model("reset");
    reset = 1'b1;

    run_vecs(0, 5);

    // Scenario 2: two full laps with enable high.
    for (int i = 0; i <= 2 * CMOD; i++) begin
      tick(i % CMOD, 1, 0, 0);
      check_model("count");
    end
    chk("count wrap_count", wrap_count, 2);
    chk("count locked", locked, 1);

    run_vecs(6, 14);

    // Scenario 4: cnt_reset to 0 is not a wrap, holding is fine, a jump while held is an error.
    tick(3, 1, 0, 0); check_model("creset");
    tick(4, 1, 0, 0); check_model("creset");
    tick(5, 1, 1, 0); check_model("creset");
    tick(0, 1, 0, 0); check_model("creset");
    chk("creset wrap_count", wrap_count, 2);
    chk("creset error", error, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(i, 1, 0, 0);
      check_model("recount");
    end
    for (int i = 0; i < 11; i++) begin
      tick(6, 0, 0, 0);
      check_model("hold");
      chk("hold error", error, 0);
    end
    tick(7, 0, 0, 0);
    check_model("holdjump");
    chk("holdjump error", error, 1);
    chk("holdjump error_count", error_count, 2);

    // Scenario 5: saturate the 2-bit error counter, then clear on a mismatch edge.
    v = 7;
    for (int i = 0; i < 3; i++) begin
      relock(v, "sat relock");
      v = (v + 1) % CMOD;
      tick(v, 0, 0, 0);
      check_model("sat");
      chk("sat error", error, 1);
    end
    chk("sat error_count", error_count, EMAX);
    relock(v, "clr relock");
    v = (v + 1) % CMOD;
    tick(v, 0, 0, 1);
    check_model("clr");
    chk("clr error", error, 1);
    chk("clr fault", fault, 1);
    chk("clr error_count", error_count, 0);

    // Scenario 6: one wrap while locked, then asynchronous reset between edges.
    relock(v, "wrap relock");
    for (int k = 0; k < CMOD; k++) begin
      tick(v, 1, 0, 0);
      check_model("wrap");
      v = (v + 1) % CMOD;
    end
    tick(v, 0, 0, 0);
    check_model("wrap");
    chk("pre-reset wrap_count", wrap_count, 1);
    chk("pre-reset locked", locked, 1);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async locked", locked, 0);
    chk("async fault", fault, 0);
    chk("async wrap_count", wrap_count, 0);
    chk("async error_count", error_count, 0);
    #10;
    reset = 1'b1;
    for (int i = 0; i < TH + 1; i++) begin
      tick(0, 0, 0, 0);
      check_model("relock after reset");
      chk($sformatf("relock edge%0d locked", i + 1), locked, (i == TH) ? 1 : 0);
    end

    // Randomized run: a mostly well-behaved counter with occasional glitches and clears.
    true_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      e   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 31) == 0);
      c   = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, CMOD - 1)) : true_cnt;
      tick(c, e, r, clr);
      check_model($sformatf("rand%0d", i));
      true_cnt = r ? 0 : (e ? (true_cnt + 1) % CMOD : true_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
